// File: rtl/zle_pkg.sv
// Shared definitions for the zero-length-encoding controller and its datapath:
// state codes, token widths and the longest zero run a single code can carry.
package zle_pkg;

    localparam int IN_W    = 7;
    localparam int OUT_W   = 8;
    localparam int RUN_MAX = 127;
    localparam int CNT_W   = 16;

    typedef logic [IN_W-1:0]  zle_tok_t;
    typedef logic [OUT_W-1:0] zle_code_t;

    typedef enum logic [3:0] {
        ST_START     = 4'd0,
        ST_START_T   = 4'd1,
        ST_START_E   = 4'd2,
        ST_ZEROS     = 4'd3,
        ST_ZEROS_T   = 4'd4,
        ST_ZEROS_T_T = 4'd5,
        ST_ZEROS_T_E = 4'd6,
        ST_ZEROS_E   = 4'd7,
        ST_PENDING   = 4'd8
    } zle_state_e;

    // States in which the datapath presents a code on the output stream.
    function automatic logic zle_is_emit(zle_state_e s);
        return (s == ST_START_E) || (s == ST_ZEROS_T_T) ||
               (s == ST_ZEROS_E) || (s == ST_PENDING);
    endfunction

endpackage

// File: rtl/zle_xcb_ctl_if.sv
// Stream handshake between the ZLE controller and its input/output FIFOs.
// The slave side is the controller; the master side owns the FIFO status lines.
interface zle_xcb_ctl_if;

    logic i_e;
    logic i_r;
    logic o_f;
    logic o_w;

    modport master (
        output i_e,
        output o_f,
        input  i_r,
        input  o_w
    );

    modport slave (
        input  i_e,
        input  o_f,
        output i_r,
        output o_w
    );

endinterface

// File: rtl/zle_tok_cnt.sv
// Free-running 16-bit token counter; advances by one on each enabled cycle
// and wraps naturally.
module zle_tok_cnt
    import zle_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/zle_xcb_ctl.sv
// Control FSM for a zero-run-length encoder: sequences reads of 7-bit tokens and
// writes of 8-bit codes, steering the datapath through the state output.
module zle_xcb_ctl
    import zle_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    zle_xcb_ctl_if.slave        bus,
    input  logic                flush,
    input  logic                f_start_i_eq_0,
    input  logic                f_zeros_i_eq_0,
    input  logic                f_zeros_t_cnt_eq_127,
    output logic [3:0]          state,
    output logic                busy,
    output logic [CNT_W-1:0]    n_in,
    output logic [CNT_W-1:0]    n_out
);

    zle_state_e r_state;
    zle_state_e w_next;
    logic       r_flush;
    logic       w_flush_next;
    logic       r_busy;
    logic       w_rd;
    logic       w_wr;

    // Strobes are gated by reset so nothing moves while reset is held.
    assign w_rd = !reset && ((r_state == ST_START) || (r_state == ST_ZEROS)) && !bus.i_e;
    assign w_wr = !reset && zle_is_emit(r_state) && !bus.o_f;

    always_comb begin
        w_next       = ST_START;
        w_flush_next = r_flush;
        case (r_state)
            ST_START: begin
                if (w_rd) begin
                    w_next = f_start_i_eq_0 ? ST_START_T : ST_START_E;
                end else begin
                    w_next = ST_START;
                end
            end
            ST_START_T:   w_next = ST_ZEROS;
            ST_START_E:   w_next = w_wr ? ST_START : ST_START_E;
            ST_ZEROS: begin
                if (w_rd) begin
                    w_next = f_zeros_i_eq_0 ? ST_ZEROS_T : ST_ZEROS_E;
                end else if (bus.i_e && flush) begin
                    w_next       = ST_ZEROS_T_T;
                    w_flush_next = 1'b1;
                end else begin
                    w_next = ST_ZEROS;
                end
            end
            ST_ZEROS_T:   w_next = f_zeros_t_cnt_eq_127 ? ST_ZEROS_T_T : ST_ZEROS_T_E;
            ST_ZEROS_T_T: begin
                if (w_wr) begin
                    w_next       = r_flush ? ST_START : ST_ZEROS_T_E;
                    w_flush_next = 1'b0;
                end else begin
                    w_next = ST_ZEROS_T_T;
                end
            end
            ST_ZEROS_T_E: w_next = ST_ZEROS;
            ST_ZEROS_E:   w_next = w_wr ? ST_PENDING : ST_ZEROS_E;
            ST_PENDING:   w_next = w_wr ? ST_START : ST_PENDING;
            default: begin
                w_next       = ST_START;
                w_flush_next = 1'b0;
            end
        endcase
    end

    // busy is registered from the next state so it always tracks the state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_START;
            r_flush <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_flush <= w_flush_next;
            r_busy  <= (w_next != ST_START);
        end
    end

    assign state   = r_state;
    assign busy    = r_busy;
    assign bus.i_r = w_rd;
    assign bus.o_w = w_wr;

    zle_tok_cnt u_in_cnt (
        .clock (clock),
        .reset (reset),
        .i_en  (w_rd),
        .o_cnt (n_in)
    );

    zle_tok_cnt u_out_cnt (
        .clock (clock),
        .reset (reset),
        .i_en  (w_wr),
        .o_cnt (n_out)
    );

endmodule
